// File: rtl/mem_bridge.sv
// Bridges LC-3b MAR/MDR requests to a multi-cycle physical memory port: word alignment, STB lane steering, one-cycle mem_resp.
// Optional build macro MEM_TIMEOUT_EN adds an access watchdog that completes with mem_error after TIMEOUT_CYCLES strobe cycles.
module mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TW             = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_byte,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        mem_error,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_address,
    output logic [15:0] pmem_wdata,
    output logic [1:0]  pmem_byte_enable,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t state;
    logic   tmo_hit;

`ifdef MEM_TIMEOUT_EN
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic          err_q;

    assign tmo_next = tmo_cnt + TW'(1);
    // A response arriving in the expiry cycle wins over the timeout.
    assign tmo_hit  = (state == READ || state == WRITE) && !pmem_resp
                      && (tmo_next == TW'(TIMEOUT_CYCLES));
    assign mem_error = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == READ || state == WRITE) begin
                tmo_cnt <= tmo_next;
                if (tmo_hit)
                    err_q <= 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
        end
    end
`else
    wire unused_cfg = ^TW'(TIMEOUT_CYCLES);
    assign tmo_hit   = 1'b0;
    assign mem_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            mem_resp         <= 1'b0;
            mem_rdata        <= 16'h0000;
            pmem_read        <= 1'b0;
            pmem_write       <= 1'b0;
            pmem_address     <= 16'h0000;
            pmem_wdata       <= 16'h0000;
            pmem_byte_enable <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        pmem_address <= {mem_address[15:1], 1'b0};
                        if (mem_read) begin
                            pmem_read        <= 1'b1;
                            pmem_byte_enable <= 2'b11;
                            state            <= READ;
                        end else begin
                            pmem_write <= 1'b1;
                            state      <= WRITE;
                            if (mem_byte) begin
                                pmem_wdata       <= {2{mem_wdata[7:0]}};
                                pmem_byte_enable <= mem_address[0] ? 2'b10 : 2'b01;
                            end else begin
                                pmem_wdata       <= mem_wdata;
                                pmem_byte_enable <= 2'b11;
                            end
                        end
                    end
                end
                READ: begin
                    if (pmem_resp || tmo_hit) begin
                        if (pmem_resp)
                            mem_rdata <= pmem_rdata;
                        pmem_read <= 1'b0;
                        mem_resp  <= 1'b1;
                        state     <= DONE;
                    end
                end
                WRITE: begin
                    if (pmem_resp || tmo_hit) begin
                        pmem_write <= 1'b0;
                        mem_resp   <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    mem_resp <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: expected mem_rdata per access is queued at issue and checked at mem_resp.
`timescale 1ns/1ps
module tb_mem_bridge;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read = 1'b0, mem_write = 1'b0, mem_byte = 1'b0;
    logic [15:0] mem_address = '0, mem_wdata = '0;
    logic        mem_resp, mem_error;
    logic [15:0] mem_rdata;
    logic        pmem_read, pmem_write;
    logic [15:0] pmem_address, pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata = '0;
    logic        pmem_resp = 1'b0;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_rdata = 16'h0000;

    always #5 clk = ~clk;

    mem_bridge #(.TIMEOUT_CYCLES(TMO), .TW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte(mem_byte),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input string tag, input int max_cyc, output int n);
        n = 0;
        while (mem_resp !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        chk({tag, "_resp"}, {31'b0, mem_resp}, 32'd1);
    endtask

    task automatic check_pop(input string tag);
        logic [15:0] e;
        chk({tag, "_sbq"}, exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, {16'b0, mem_rdata}, {16'b0, e});
        end
    endtask

    task automatic do_read(input string tag, input logic [15:0] addr, input logic [15:0] data,
                           input int d, input logic both);
        int n;
        mem_read = 1'b1; mem_write = both; mem_byte = 1'b0;
        mem_address = addr; mem_wdata = 16'h5A5A;
        exp_q.push_back(data);
        last_rdata = data;
        step();
        chk({tag, "_rd"},   {31'b0, pmem_read},  32'd1);
        chk({tag, "_nowr"}, {31'b0, pmem_write}, 32'd0);
        chk({tag, "_addr"}, {16'b0, pmem_address}, {16'b0, addr[15:1], 1'b0});
        chk({tag, "_be"},   {30'b0, pmem_byte_enable}, 32'd3);
        mem_address = ~addr;
        repeat (d) begin
            step();
            chk({tag, "_rd_hold"},   {31'b0, pmem_read},  32'd1);
            chk({tag, "_nowr_hold"}, {31'b0, pmem_write}, 32'd0);
            chk({tag, "_addr_hold"}, {16'b0, pmem_address}, {16'b0, addr[15:1], 1'b0});
            chk({tag, "_early"},     {31'b0, mem_resp},   32'd0);
        end
        pmem_resp = 1'b1; pmem_rdata = data;
        step();
        pmem_resp = 1'b0; pmem_rdata = 16'hDEAD;
        wait_resp(tag, 8, n);
        chk({tag, "_lat"}, n, 32'd0);
        check_pop(tag);
        chk({tag, "_err"},    {31'b0, mem_error}, 32'd0);
        chk({tag, "_rd_off"}, {31'b0, pmem_read}, 32'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        step();
        chk({tag, "_pulse"}, {31'b0, mem_resp}, 32'd0);
        chk({tag, "_nowr_end"}, {31'b0, pmem_write}, 32'd0);
    endtask

    task automatic do_write(input string tag, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic byte_wr, input logic [15:0] exp_wdata,
                            input logic [1:0] exp_be, input int d);
        int n;
        mem_read = 1'b0; mem_write = 1'b1; mem_byte = byte_wr;
        mem_address = addr; mem_wdata = wdata;
        exp_q.push_back(last_rdata);
        step();
        chk({tag, "_wr"},    {31'b0, pmem_write}, 32'd1);
        chk({tag, "_nord"},  {31'b0, pmem_read},  32'd0);
        chk({tag, "_addr"},  {16'b0, pmem_address}, {16'b0, addr[15:1], 1'b0});
        chk({tag, "_wdata"}, {16'b0, pmem_wdata}, {16'b0, exp_wdata});
        chk({tag, "_be"},    {30'b0, pmem_byte_enable}, {30'b0, exp_be});
        mem_address = ~addr; mem_wdata = ~wdata; mem_byte = ~byte_wr;
        repeat (d) begin
            step();
            chk({tag, "_wr_hold"},    {31'b0, pmem_write}, 32'd1);
            chk({tag, "_wdata_hold"}, {16'b0, pmem_wdata}, {16'b0, exp_wdata});
            chk({tag, "_be_hold"},    {30'b0, pmem_byte_enable}, {30'b0, exp_be});
        end
        pmem_resp = 1'b1; pmem_rdata = 16'hF00D;
        step();
        pmem_resp = 1'b0;
        wait_resp(tag, 8, n);
        chk({tag, "_lat"}, n, 32'd0);
        check_pop(tag);
        chk({tag, "_wr_off"}, {31'b0, pmem_write}, 32'd0);
        mem_write = 1'b0;
        step();
        chk({tag, "_pulse"}, {31'b0, mem_resp}, 32'd0);
    endtask

    initial begin
        int n;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_resp",  {31'b0, mem_resp},  32'd0);
        chk("rst_rdata", {16'b0, mem_rdata}, 32'd0);
        chk("rst_err",   {31'b0, mem_error}, 32'd0);
        chk("rst_rd",    {31'b0, pmem_read}, 32'd0);
        chk("rst_wr",    {31'b0, pmem_write}, 32'd0);
        chk("rst_addr",  {16'b0, pmem_address}, 32'd0);
        chk("rst_wdata", {16'b0, pmem_wdata}, 32'd0);
        chk("rst_be",    {30'b0, pmem_byte_enable}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        do_read("word_rd", 16'h3001, 16'hBEEF, 3, 1'b0);
        do_write("stb_odd",  16'h0043, 16'h12A5, 1'b1, 16'hA5A5, 2'b10, 1);
        do_write("stb_even", 16'h0042, 16'h12A5, 1'b1, 16'hA5A5, 2'b01, 0);
        do_write("word_wr",  16'h2005, 16'h1234, 1'b0, 16'h1234, 2'b11, 2);
        do_read("both_rd", 16'h0100, 16'h7E57, 1, 1'b1);
        do_read("b2b_a", 16'h0010, 16'h1111, 0, 1'b0);
        do_read("b2b_b", 16'h0012, 16'h2222, 0, 1'b0);

        pmem_resp = 1'b1; pmem_rdata = 16'h9999;
        step();
        pmem_resp = 1'b0;
        chk("idle_resp_ign",  {31'b0, mem_resp},  32'd0);
        chk("idle_rdata_ign", {16'b0, mem_rdata}, {16'b0, last_rdata});
        chk("idle_no_rd",     {31'b0, pmem_read}, 32'd0);

        mem_write = 1'b1; mem_byte = 1'b0; mem_address = 16'h0100; mem_wdata = 16'hCAFE;
        step();
        chk("rstmid_wr", {31'b0, pmem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_wr_drop", {31'b0, pmem_write}, 32'd0);
        chk("rstmid_addr",    {16'b0, pmem_address}, 32'd0);
        chk("rstmid_rdata",   {16'b0, mem_rdata}, 32'd0);
        last_rdata = 16'h0000;
        mem_write = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("rstmid_resp", {31'b0, mem_resp},   32'd0);
        chk("rstmid_idle", {30'b0, pmem_read, pmem_write}, 32'd0);
        do_read("post_rst", 16'h4444, 16'hA1B2, 1, 1'b0);

`ifdef MEM_TIMEOUT_EN
        mem_read = 1'b1; mem_address = 16'h0200;
        exp_q.push_back(last_rdata);
        pmem_rdata = 16'h0BAD;
        step();
        chk("tmo_rd", {31'b0, pmem_read}, 32'd1);
        wait_resp("tmo", TMO + 4, n);
        chk("tmo_lat",    n, TMO);
        chk("tmo_err",    {31'b0, mem_error}, 32'd1);
        chk("tmo_rd_off", {31'b0, pmem_read}, 32'd0);
        check_pop("tmo");
        mem_read = 1'b0;
        step();
        chk("tmo_pulse",     {31'b0, mem_resp},  32'd0);
        chk("tmo_err_pulse", {31'b0, mem_error}, 32'd0);
`endif

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory-side stage directly downstream of the LC-3b datapath and control FSM.
- Accepts single-outstanding read/write requests (datapath MAR/MDR, control read/write/byte strobes) and drives the multi-cycle physical memory port.
- Returns a registered read word plus a one-cycle mem_resp.
- Handles word alignment and STB byte-lane steering, so the datapath stays free of memory-protocol logic.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles a pmem access may stay outstanding (used only with MEM_TIMEOUT_EN).
- TW, 8: width of timeout counter; TIMEOUT_CYCLES must be < 2**TW.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- mem_read  input  1  read request from control; held until mem_resp.
- mem_write  input  1  write request from control; held until mem_resp.
- mem_byte  input  1  1 = byte write (STB), 0 = word access.
- mem_address  input  16  byte address (MAR output).
- mem_wdata  input  16  write data (MDR output).
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  16  registered read word.
- mem_error  output  1  one-cycle timeout flag, coincident with mem_resp.
- pmem_read  output  1  physical read strobe.
- pmem_write  output  1  physical write strobe.
- pmem_address  output  16  word-aligned address.
- pmem_wdata  output  16  lane-steered write data.
- pmem_byte_enable  output  2  lane enables, bit0 = low byte.
- pmem_rdata  input  16  physical read data, valid with pmem_resp.
- pmem_resp  input  1  physical completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: mem_resp, mem_rdata=16'h0000, mem_error, pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable. Strobes drop immediately, including mid-access. The timeout counter clears.
- States: IDLE, READ, WRITE, DONE.
- IDLE: if mem_read, go to READ; else if mem_write, go to WRITE. Read wins if both are high. On acceptance, register the following:
  - pmem_address = {mem_address[15:1],1'b0}.
  - For a write, lanes/data: mem_byte=0 gives be=2'b11, wdata=mem_wdata. mem_byte=1 gives wdata={mem_wdata[7:0],mem_wdata[7:0]}, be=2'b01 if mem_address[0]=0, else 2'b10.
  - For a read, be=2'b11.
- READ: pmem_read=1, with address/be held stable. On pmem_resp: capture mem_rdata<=pmem_rdata, drop pmem_read, go to DONE.
- WRITE: pmem_write=1, with address/data/be held stable. On pmem_resp: drop pmem_write, go to DONE. mem_rdata is unchanged.
- DONE: mem_resp=1 for exactly one cycle, then IDLE. A request still high during DONE is ignored. IDLE re-evaluates the request on the next cycle.
- Latency: request first seen in IDLE at cycle t; pmem strobe at t+1; pmem_resp at cycle k; mem_resp at k+1. Minimum is 2 cycles (pmem_resp at t+1 gives mem_resp at t+2).
- pmem_resp in IDLE or DONE is ignored.
- mem_rdata holds its value until the next successful read.
- Inputs changing while in READ/WRITE have no effect on pmem outputs (registered at acceptance).

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - The counter clears on entering READ/WRITE and increments each cycle without pmem_resp.
  - When the counter reaches TIMEOUT_CYCLES with no pmem_resp, drop the strobe, go to DONE, and assert mem_resp and mem_error together for one cycle. mem_rdata is unchanged.
  - pmem_resp in the same cycle as expiry counts as success; mem_error stays 0.
- Undefined: no counter; the bridge waits indefinitely and mem_error is tied 0.

Test Plan:
1. Word read: mem_read=1, addr=16'h3001; pmem_resp 3 cycles after strobe with rdata=16'hBEEF. Required: pmem_address=16'h3000, be=2'b11; mem_rdata=16'hBEEF; mem_resp single pulse, 1 cycle after pmem_resp.
2. STB odd address: mem_write=1, mem_byte=1, addr=16'h0043, wdata=16'h12A5. Required: pmem_address=16'h0042, pmem_wdata=16'hA5A5, be=2'b10. STB even address 16'h0042: be=2'b01.
3. Simultaneous mem_read=1 and mem_write=1 in IDLE. Required: pmem_read only; pmem_write stays 0 throughout.
4. Back-to-back: second read issued in the cycle after mem_resp, with pmem_resp immediate. Required: mem_resp at t+2 for each access; no request lost or duplicated.
5. Reset mid-access: rst_n low while pmem_write=1. Required: pmem_write=0 with no clock edge; after release, state is IDLE and mem_resp=0.
6. MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4: read with no pmem_resp. Required: pmem_read drops, mem_resp=mem_error=1 for one cycle, mem_rdata retains its prior value.
